// File: rtl/raytracer_pkg.sv
// rtl/raytracer_pkg.sv - shared types and helpers for the ray-tracing coprocessor pixel path
package raytracer_pkg;

    localparam int DEFAULT_FRAME_W = 32;
    localparam int DEFAULT_FRAME_H = 32;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DRAIN
    } axis_tx_state_e;

    function automatic logic [31:0] pack_pixel(input rgb_t p);
        return {8'h00, p.r, p.g, p.b};
    endfunction

endpackage

// File: rtl/pixel_axis_tx_if.sv
// rtl/pixel_axis_tx_if.sv - renderer pixel input and AXI4-Stream output bundle
interface pixel_axis_tx_if;

    logic        pix_valid;
    logic [23:0] pix_data;
    logic        pix_ready;
    logic        m_axis_tvalid;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tlast;
    logic        m_axis_tready;

    modport slave (
        input  pix_valid, pix_data, m_axis_tready,
        output pix_ready, m_axis_tvalid, m_axis_tdata, m_axis_tlast
    );

    modport master (
        output pix_valid, pix_data, m_axis_tready,
        input  pix_ready, m_axis_tvalid, m_axis_tdata, m_axis_tlast
    );

endinterface

// File: rtl/axis_beat_fifo.sv
// rtl/axis_beat_fifo.sv - small register FIFO carrying {last, data} beats with registered flags
module axis_beat_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 33
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_empty,
    output logic             o_full,
    output logic             o_full_next
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             r_empty;
    logic             r_full;
    logic [AW:0]      w_count_next;
    logic             w_push;
    logic             w_pop;

    assign w_push       = i_push && !r_full;
    assign w_pop        = i_pop && !r_empty;
    assign w_count_next = r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    assign o_full_next  = (w_count_next == (AW+1)'(DEPTH));
    assign o_data       = r_mem[r_rd_ptr];
    assign o_empty      = r_empty;
    assign o_full       = r_full;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_empty  <= 1'b1;
            r_full   <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= w_count_next;
            r_empty <= (w_count_next == '0);
            r_full  <= o_full_next;
        end
    end

endmodule

// File: rtl/pixel_axis_tx.sv
// rtl/pixel_axis_tx.sv - frames renderer pixels into an AXI4-Stream with tlast on the final pixel
module pixel_axis_tx
    import raytracer_pkg::*;
#(
    parameter int FRAME_W    = DEFAULT_FRAME_W,
    parameter int FRAME_H    = DEFAULT_FRAME_H,
    parameter int FIFO_DEPTH = 2
) (
    input  logic            aclk,
    input  logic            aresetn,
    input  logic            start,
    output logic            busy,
    output logic            done,
    pixel_axis_tx_if.slave  bus
);

    localparam int NPIX = FRAME_W * FRAME_H;
    localparam int CW   = $clog2(NPIX);

    axis_tx_state_e r_state;
    axis_tx_state_e w_state_next;
    logic [CW-1:0]  r_count;
    logic           r_pix_ready;
    logic           r_done;
    logic           w_accept;
    logic           w_last_pix;
    logic           w_beat_done;
    logic [32:0]    w_fifo_din;
    logic [32:0]    w_fifo_dout;
    logic           w_empty;
    logic           w_full;
    logic           w_full_next;

    assign w_accept    = bus.pix_valid && r_pix_ready && !w_full;
    assign w_last_pix  = (r_count == CW'(NPIX - 1));
    assign w_fifo_din  = {w_last_pix, pack_pixel(rgb_t'(bus.pix_data))};
    assign w_beat_done = !w_empty && bus.m_axis_tready && w_fifo_dout[32];

    axis_beat_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (33)
    ) u_fifo (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .i_push      (w_accept),
        .i_data      (w_fifo_din),
        .i_pop       (bus.m_axis_tready),
        .o_data      (w_fifo_dout),
        .o_empty     (w_empty),
        .o_full      (w_full),
        .o_full_next (w_full_next)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start)                   w_state_next = STREAM;
            STREAM:  if (w_accept && w_last_pix)  w_state_next = DRAIN;
            DRAIN:   if (w_beat_done)             w_state_next = IDLE;
            default:                              w_state_next = IDLE;
        endcase
    end

    // pix_ready looks at next-cycle occupancy so a pop while full reopens the input one cycle later
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state     <= IDLE;
            r_count     <= '0;
            r_pix_ready <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_pix_ready <= (w_state_next == STREAM) && !w_full_next;
            r_done      <= (r_state == DRAIN) && w_beat_done;
            if (r_state == IDLE && start) begin
                r_count <= '0;
            end else if (w_accept) begin
                r_count <= r_count + CW'(1);
            end
        end
    end

    assign busy              = (r_state == STREAM) || (r_state == DRAIN);
    assign done              = r_done;
    assign bus.pix_ready     = r_pix_ready;
    assign bus.m_axis_tvalid = !w_empty;
    assign bus.m_axis_tdata  = w_fifo_dout[31:0];
    assign bus.m_axis_tlast  = w_fifo_dout[32] && !w_empty;

endmodule

// File: tb/tb_pixel_axis_tx.sv
// tb/tb_pixel_axis_tx.sv - randomized scoreboard bench for pixel_axis_tx
module tb_pixel_axis_tx;
    import raytracer_pkg::*;

    localparam int N     = DEFAULT_FRAME_W * DEFAULT_FRAME_H;
    localparam int DEPTH = 2;

    logic aclk    = 1'b0;
    logic aresetn = 1'b0;
    logic start   = 1'b0;
    logic start2  = 1'b0;
    logic busy, done, busy2, done2;

    always #5 aclk = ~aclk;

    pixel_axis_tx_if bus ();
    pixel_axis_tx_if bus2 ();

    pixel_axis_tx #(
        .FRAME_W (DEFAULT_FRAME_W), .FRAME_H (DEFAULT_FRAME_H), .FIFO_DEPTH (DEPTH)
    ) dut (
        .aclk (aclk), .aresetn (aresetn), .start (start), .busy (busy), .done (done), .bus (bus)
    );

    pixel_axis_tx #(
        .FRAME_W (2), .FRAME_H (1), .FIFO_DEPTH (2)
    ) dut_small (
        .aclk (aclk), .aresetn (aresetn), .start (start2), .busy (busy2), .done (done2), .bus (bus2)
    );

    int          n_vec = 0;
    int          n_err = 0;
    logic [23:0] src [N];
    int          sent = 0, got = 0;
    bit          armed = 0, exp_busy = 0, exp_done = 0;
    int          dut_beats = 0, dut_last = 0;

    task automatic chk(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_vec++;
        if (actual !== expected) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, actual, expected, $time);
        end
    endtask

    // One clock: drive inputs at the falling edge, then check against the frame model.
    task automatic cycle(input bit do_start, input bit v, input bit rdy);
        bit exp_ready, exp_valid, was_busy;
        @(negedge aclk);
        start             = do_start;
        bus.pix_valid     = v;
        bus.pix_data      = (sent < N) ? src[sent] : 24'($urandom);
        bus.m_axis_tready = rdy;
        #1;
        exp_ready = armed && (sent < N) && ((sent - got) < DEPTH);
        exp_valid = (sent > got);
        was_busy  = exp_busy;
        chk("pix_ready", 32'(bus.pix_ready), 32'(exp_ready));
        chk("tvalid", 32'(bus.m_axis_tvalid), 32'(exp_valid));
        chk("busy", 32'(busy), 32'(exp_busy));
        chk("done", 32'(done), 32'(exp_done));
        if (exp_valid) begin
            chk("tdata", bus.m_axis_tdata, {8'h00, src[got]});
            chk("tlast", 32'(bus.m_axis_tlast), 32'(got == N - 1));
        end
        if (bus.m_axis_tvalid && rdy) begin
            dut_beats++;
            if (bus.m_axis_tlast) dut_last++;
        end
        exp_done = 0;
        if (exp_valid && rdy) begin
            if (got == N - 1) begin
                exp_done = 1;
                exp_busy = 0;
                armed    = 0;
            end
            got++;
        end
        if (exp_ready && v) sent++;
        if (do_start && !was_busy) begin
            armed    = 1;
            exp_busy = 1;
            sent     = 0;
            got      = 0;
        end
    endtask

    task automatic do_reset();
        @(negedge aclk);
        aresetn       = 1'b0;
        start         = 1'b0;
        bus.pix_valid = 1'b0;
        #1;
        chk("rst_tvalid", 32'(bus.m_axis_tvalid), 32'h0);
        chk("rst_tdata", bus.m_axis_tdata, 32'h0);
        chk("rst_tlast", 32'(bus.m_axis_tlast), 32'h0);
        chk("rst_pix_ready", 32'(bus.pix_ready), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        @(negedge aclk);
        aresetn  = 1'b1;
        sent     = 0;
        got      = 0;
        armed    = 0;
        exp_busy = 0;
        exp_done = 0;
    endtask

    // mode 0: continuous, 1: tready 1,0,0,1, 2: starved source, 3: random tready + stray start, 4: reset mid-frame
    task automatic run_frame(input int mode, input int abort_at);
        int c;
        bit v, rdy;
        for (int k = 0; k < N; k++) src[k] = (mode == 0) ? 24'(k) : 24'($urandom);
        dut_beats = 0;
        dut_last  = 0;
        cycle(1'b1, 1'b0, 1'b1);
        c = 0;
        while (exp_busy && c < 8000) begin
            if (abort_at > 0 && got >= abort_at) begin
                do_reset();
                return;
            end
            case (mode)
                1:       begin v = 1'b1;          rdy = (c % 4 == 0) || (c % 4 == 3); end
                2:       begin v = (c % 3 == 0);  rdy = 1'b1; end
                3:       begin v = 1'b1;          rdy = 1'($urandom); end
                default: begin v = 1'b1;          rdy = 1'b1; end
            endcase
            cycle(mode == 3 && c == 100, v, rdy);
            c++;
        end
        chk("frame_timeout", 32'(exp_busy), 32'h0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b1);
        chk("frame_beats", 32'(dut_beats), 32'(N));
        chk("frame_tlast_count", 32'(dut_last), 32'h1);
    endtask

    initial begin
        logic [23:0] px [2];
        int k, b, nd;
        bus.pix_valid      = 1'b0;
        bus.pix_data       = '0;
        bus.m_axis_tready  = 1'b0;
        bus2.pix_valid     = 1'b0;
        bus2.pix_data      = '0;
        bus2.m_axis_tready = 1'b0;

        do_reset();
        run_frame(0, 0);
        run_frame(1, 0);
        run_frame(2, 0);
        run_frame(3, 0);
        run_frame(4, 500);
        run_frame(0, 0);

        px[0] = 24'hFF8040;
        px[1] = 24'h102030;
        k  = 0;
        b  = 0;
        nd = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge aclk);
            start2             = (c == 0);
            bus2.pix_valid     = (c > 0) && (k < 2);
            bus2.pix_data      = px[(k < 2) ? k : 0];
            bus2.m_axis_tready = 1'b1;
            #1;
            if (bus2.m_axis_tvalid) begin
                if (b < 2) begin
                    chk("small_tdata", bus2.m_axis_tdata, {8'h00, px[b]});
                    chk("small_tlast", 32'(bus2.m_axis_tlast), 32'(b == 1));
                end
                b++;
            end
            if (done2) nd++;
            if (bus2.pix_valid && bus2.pix_ready) k++;
        end
        chk("small_beats", 32'(b), 32'd2);
        chk("small_done", 32'(nd), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
